huffman_tree_ctrl: RTL and testbench

- Sequencer for the Huffman code-construction stage that follows the 6-symbol counting stage.
- Accepts one set of six symbol counts on a cnt_valid pulse, then runs iterative two-minimum merges. Each merge step takes 2 cycles: SELECT, then MERGE.
- Produces per-symbol code words HCn and length masks Mn, and pulses code_valid for one cycle when done.
- Runs one tree build at a time; the upstream counter must wait for a new frame until done.

---
 rtl/huffman_pkg.sv | 24 ++
 rtl/huffman_min2_sel.sv | 42 ++++
 rtl/huffman_tree_ctrl.sv | 178 +++++++++++++++++
 tb/tb_huffman_tree_ctrl.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/huffman_pkg.sv
// Shared constants, state encoding and vector types for the Huffman tree sequencer.
package huffman_pkg;

  localparam int NSYM = 6;
  localparam int WW   = 11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SELECT = 2'd1,
    MERGE  = 2'd2
  } state_t;

  typedef logic [NSYM-1:0]         grp_t;
  typedef logic [NSYM-1:0][WW-1:0] wvec_t;
  typedef logic [2:0]              idx_t;

  function automatic logic [2:0] count_ones(input grp_t g);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < NSYM; i++) n = n + {2'b00, g[i]};
    return n;
  endfunction

endpackage

// File: rtl/huffman_min2_sel.sv
// Combinational two-minimum finder over the active groups; lowest index wins ties.
module huffman_min2_sel
  import huffman_pkg::*;
(
  input  wvec_t w,
  input  grp_t  active,
  output idx_t  min1,
  output idx_t  min2
);

  logic [WW-1:0] best1_s;
  logic [WW-1:0] best2_s;
  logic          found1_s;
  logic          found2_s;
  logic          take1_s;
  logic          take2_s;

  // Two linear scans; strict less-than keeps the earlier index on equal weights.
  always_comb begin
    best1_s  = '0;
    best2_s  = '0;
    found1_s = 1'b0;
    found2_s = 1'b0;
    take1_s  = 1'b0;
    take2_s  = 1'b0;
    min1     = '0;
    min2     = '0;
    for (int i = 0; i < NSYM; i++) begin
      take1_s  = active[i] && (!found1_s || (w[i] < best1_s));
      best1_s  = take1_s ? w[i] : best1_s;
      min1     = take1_s ? idx_t'(i) : min1;
      found1_s = found1_s | take1_s;
    end
    for (int i = 0; i < NSYM; i++) begin
      take2_s  = active[i] && (idx_t'(i) != min1) && (!found2_s || (w[i] < best2_s));
      best2_s  = take2_s ? w[i] : best2_s;
      min2     = take2_s ? idx_t'(i) : min2;
      found2_s = found2_s | take2_s;
    end
  end

endmodule

// File: rtl/huffman_tree_ctrl.sv
// Huffman code-construction sequencer: SELECT/MERGE loop over six symbol weights.
// Optional HUFF_ZERO_SKIP_EN excludes zero-count symbols from the tree.
module huffman_tree_ctrl
  import huffman_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       cnt_valid,
  input  logic [7:0] CNT1,
  input  logic [7:0] CNT2,
  input  logic [7:0] CNT3,
  input  logic [7:0] CNT4,
  input  logic [7:0] CNT5,
  input  logic [7:0] CNT6,
  output logic       busy,
  output logic       code_valid,
  output logic [7:0] HC1,
  output logic [7:0] HC2,
  output logic [7:0] HC3,
  output logic [7:0] HC4,
  output logic [7:0] HC5,
  output logic [7:0] HC6,
  output logic [7:0] M1,
  output logic [7:0] M2,
  output logic [7:0] M3,
  output logic [7:0] M4,
  output logic [7:0] M5,
  output logic [7:0] M6
);

  state_t                    state_r, state_s;
  wvec_t                     w_r;
  logic [NSYM-1:0][NSYM-1:0] grp_r;
  grp_t                      active_r, load_active_s, active_after_s;
  logic [NSYM-1:0][2:0]      len_r;
  logic [NSYM-1:0][7:0]      hc_r, m_r, load_m_s, cnt_s;
  idx_t                      min1_r, min2_r, min1_s, min2_s;
  logic                      busy_r, code_valid_r, busy_s, code_valid_s;

  assign cnt_s          = {CNT6, CNT5, CNT4, CNT3, CNT2, CNT1};
  assign active_after_s = active_r & ~(grp_t'(1) << min1_r);

  huffman_min2_sel u_sel (
    .w      (w_r),
    .active (active_r),
    .min1   (min1_s),
    .min2   (min2_s)
  );

  // Load-time participation; a lone surviving symbol gets a one-bit code of 0.
  always_comb begin
    load_active_s = '0;
    load_m_s      = '0;
    for (int i = 0; i < NSYM; i++) begin
`ifdef HUFF_ZERO_SKIP_EN
      load_active_s[i] = (cnt_s[i] != 8'd0);
`else
      load_active_s[i] = 1'b1;
`endif
    end
    if (count_ones(load_active_s) == 3'd1) begin
      for (int i = 0; i < NSYM; i++) load_m_s[i] = {7'd0, load_active_s[i]};
    end else begin
      load_m_s = '0;
    end
  end

  // Next state, done pulse and busy flag.
  always_comb begin
    state_s      = state_r;
    code_valid_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (cnt_valid) begin
          if (count_ones(load_active_s) > 3'd1) begin
            state_s = SELECT;
          end else begin
            state_s      = IDLE;
            code_valid_s = 1'b1;
          end
        end else begin
          state_s = IDLE;
        end
      end
      SELECT: state_s = MERGE;
      MERGE: begin
        if (count_ones(active_after_s) > 3'd1) begin
          state_s = SELECT;
        end else begin
          state_s      = IDLE;
          code_valid_s = 1'b1;
        end
      end
      default: state_s = IDLE;
    endcase
    busy_s = (state_s != IDLE) || code_valid_s;
  end

  // Control registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= IDLE;
      busy_r       <= 1'b0;
      code_valid_r <= 1'b0;
    end else begin
      state_r      <= state_s;
      busy_r       <= busy_s;
      code_valid_r <= code_valid_s;
    end
  end

  // Weights, groups, code words and masks.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_r      <= '0;
      grp_r    <= '0;
      active_r <= '0;
      len_r    <= '0;
      hc_r     <= '0;
      m_r      <= '0;
      min1_r   <= '0;
      min2_r   <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (cnt_valid) begin
            for (int i = 0; i < NSYM; i++) begin
              w_r[i]   <= {3'b000, cnt_s[i]};
              grp_r[i] <= grp_t'(1) << i;
            end
            active_r <= load_active_s;
            len_r    <= '0;
            hc_r     <= '0;
            m_r      <= load_m_s;
          end
        end
        SELECT: begin
          min1_r <= min1_s;
          min2_r <= min2_s;
        end
        MERGE: begin
          // Lighter subtree takes the 1 branch, the other takes 0, at each symbol's own depth.
          for (int s = 0; s < NSYM; s++) begin
            if (grp_r[min1_r][s]) begin
              hc_r[s][len_r[s]] <= 1'b1;
              len_r[s]          <= len_r[s] + 3'd1;
              m_r[s]            <= {m_r[s][6:0], 1'b1};
            end else if (grp_r[min2_r][s]) begin
              hc_r[s][len_r[s]] <= 1'b0;
              len_r[s]          <= len_r[s] + 3'd1;
              m_r[s]            <= {m_r[s][6:0], 1'b1};
            end
          end
          grp_r[min2_r]    <= grp_r[min2_r] | grp_r[min1_r];
          w_r[min2_r]      <= w_r[min2_r] + w_r[min1_r];
          active_r[min1_r] <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign busy       = busy_r;
  assign code_valid = code_valid_r;
  assign HC1 = hc_r[0];
  assign HC2 = hc_r[1];
  assign HC3 = hc_r[2];
  assign HC4 = hc_r[3];
  assign HC5 = hc_r[4];
  assign HC6 = hc_r[5];
  assign M1  = m_r[0];
  assign M2  = m_r[1];
  assign M3  = m_r[2];
  assign M4  = m_r[3];
  assign M5  = m_r[4];
  assign M6  = m_r[5];

endmodule

// File: tb/tb_huffman_tree_ctrl.sv
// Self-checking bench for huffman_tree_ctrl against a behavioural Huffman model.
module tb_huffman_tree_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       cnt_valid;
  logic [7:0] cnt1, cnt2, cnt3, cnt4, cnt5, cnt6;
  logic       busy, code_valid;
  logic [7:0] hc1, hc2, hc3, hc4, hc5, hc6;
  logic [7:0] m1, m2, m3, m4, m5, m6;
  logic [47:0] hc_v, m_v;

  int n_checks = 0;
  int n_pass   = 0;
  logic [5:0][7:0] exp_hc, exp_m;
  int exp_lat;

  assign hc_v = {hc6, hc5, hc4, hc3, hc2, hc1};
  assign m_v  = {m6, m5, m4, m3, m2, m1};

  always #5 clk = ~clk;

  huffman_tree_ctrl dut (
    .clk(clk), .reset(reset), .cnt_valid(cnt_valid),
    .CNT1(cnt1), .CNT2(cnt2), .CNT3(cnt3), .CNT4(cnt4), .CNT5(cnt5), .CNT6(cnt6),
    .busy(busy), .code_valid(code_valid),
    .HC1(hc1), .HC2(hc2), .HC3(hc3), .HC4(hc4), .HC5(hc5), .HC6(hc6),
    .M1(m1), .M2(m2), .M3(m3), .M4(m4), .M5(m5), .M6(m6)
  );

  task automatic set_cnt(input logic [5:0][7:0] c);
    cnt1 = c[0]; cnt2 = c[1]; cnt3 = c[2]; cnt4 = c[3]; cnt5 = c[4]; cnt6 = c[5];
  endtask

  // Reference: repeatedly merge the two lightest live subtrees, prefixing a bit to every member.
  task automatic model(input logic [5:0][7:0] c);
    int w[6];
    bit act[6];
    logic [5:0] grp[6];
    int len[6];
    logic [7:0] hc[6];
    int a, b, n, merges;
    for (int i = 0; i < 6; i++) begin
      w[i] = int'(c[i]);
`ifdef HUFF_ZERO_SKIP_EN
      act[i] = (c[i] != 8'd0);
`else
      act[i] = 1'b1;
`endif
      grp[i] = 6'd1 << i;
      len[i] = 0;
      hc[i]  = 8'd0;
    end
    merges = 0;
    for (int it = 0; it < 6; it++) begin
      n = 0;
      for (int i = 0; i < 6; i++) n += int'(act[i]);
      if (n > 1) begin
        a = -1;
        for (int i = 0; i < 6; i++) if (act[i] && (a < 0 || w[i] < w[a])) a = i;
        b = -1;
        for (int i = 0; i < 6; i++) if (act[i] && i != a && (b < 0 || w[i] < w[b])) b = i;
        for (int s = 0; s < 6; s++) begin
          if (grp[a][s]) begin
            hc[s] = hc[s] | (8'd1 << len[s]);
            len[s]++;
          end else if (grp[b][s]) begin
            len[s]++;
          end
        end
        grp[b] = grp[b] | grp[a];
        w[b]   = w[b] + w[a];
        act[a] = 1'b0;
        merges++;
      end
    end
    if (merges == 0) for (int i = 0; i < 6; i++) if (act[i]) len[i] = 1;
    for (int i = 0; i < 6; i++) begin
      exp_hc[i] = hc[i];
      exp_m[i]  = 8'((1 << len[i]) - 1);
    end
    exp_lat = 2 * merges;
  endtask

  // Run one frame; optionally pulse an extra (to-be-ignored) cnt_valid at cycle inj_k.
  task automatic do_frame(input logic [5:0][7:0] c, input int inj_k,
                          input logic [5:0][7:0] ic, input string name);
    int k, cv_k, busy_cnt;
    model(c);
    @(negedge clk);
    cnt_valid = 1'b1;
    set_cnt(c);
    @(negedge clk);
    cnt_valid = 1'b0;
    k = 1; cv_k = 0; busy_cnt = 0;
    while (cv_k == 0 && k <= 60) begin
      if (busy) busy_cnt++;
      if (code_valid) begin
        cv_k = k;
      end else begin
        if (k == inj_k) begin
          cnt_valid = 1'b1;
          set_cnt(ic);
        end
        @(negedge clk);
        cnt_valid = 1'b0;
        k++;
      end
    end
    n_checks++;
    if (cv_k !== exp_lat + 1) $display("FAIL %s latency: got %0d expected %0d", name, cv_k, exp_lat + 1);
    else n_pass++;
    n_checks++;
    if (hc_v !== exp_hc) $display("FAIL %s hc: got %h expected %h", name, hc_v, exp_hc);
    else n_pass++;
    n_checks++;
    if (m_v !== exp_m) $display("FAIL %s mask: got %h expected %h", name, m_v, exp_m);
    else n_pass++;
    n_checks++;
    if (busy_cnt !== exp_lat + 1) $display("FAIL %s busy_cycles: got %0d expected %0d", name, busy_cnt, exp_lat + 1);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({code_valid, busy} !== 2'b00) $display("FAIL %s after_done cv/busy: got %b expected 00", name, {code_valid, busy});
    else n_pass++;
    n_checks++;
    if ({hc_v, m_v} !== {exp_hc, exp_m}) $display("FAIL %s hold: got %h expected %h", name, {hc_v, m_v}, {exp_hc, exp_m});
    else n_pass++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cnt_valid = 1'b0;
    set_cnt('0);
    repeat (2) @(negedge clk);
    n_checks++;
    if ({hc_v, m_v} !== 96'd0) $display("FAIL reset outputs: got %h expected 0", {hc_v, m_v});
    else n_pass++;
    n_checks++;
    if ({busy, code_valid} !== 2'b00) $display("FAIL reset busy/cv: got %b expected 00", {busy, code_valid});
    else n_pass++;
    reset = 1'b0;
  endtask

  task automatic test_known();
    do_frame({8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1}, 0, '0, "known");
`ifndef HUFF_ZERO_SKIP_EN
    n_checks++;
    if (hc_v !== 48'h00_02_03_02_06_07) $display("FAIL known hc_const: got %h expected 000203020607", hc_v);
    else n_pass++;
    n_checks++;
    if (m_v !== 48'h03_03_03_07_0F_0F) $display("FAIL known m_const: got %h expected 030303070f0f", m_v);
    else n_pass++;
`endif
  endtask

  task automatic test_all_zero();
    do_frame('0, 0, '0, "all_zero");
`ifndef HUFF_ZERO_SKIP_EN
    n_checks++;
    if (hc_v !== 48'h00_02_06_0E_1E_1F) $display("FAIL all_zero hc_const: got %h expected 0002060e1e1f", hc_v);
    else n_pass++;
    n_checks++;
    if (m_v !== 48'h01_03_07_0F_1F_1F) $display("FAIL all_zero m_const: got %h expected 0103070f1f1f", m_v);
    else n_pass++;
`endif
  endtask

  task automatic test_ignore_busy();
    do_frame({8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1}, 4,
             {8'd0, 8'd0, 8'd0, 8'd0, 8'd50, 8'd50}, "ignore_busy");
    n_checks++;
    if (hc_v !== 48'h00_02_03_02_06_07) $display("FAIL ignore_busy hc_const: got %h expected 000203020607", hc_v);
    else n_pass++;
  endtask

  task automatic test_mid_reset();
    bit seen;
    @(negedge clk);
    cnt_valid = 1'b1;
    set_cnt({8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1});
    @(negedge clk);
    cnt_valid = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    #1;
    n_checks++;
    if ({hc_v, m_v} !== 96'd0) $display("FAIL mid_reset outputs: got %h expected 0", {hc_v, m_v});
    else n_pass++;
    n_checks++;
    if ({busy, code_valid} !== 2'b00) $display("FAIL mid_reset busy/cv: got %b expected 00", {busy, code_valid});
    else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (code_valid) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) $display("FAIL mid_reset spurious_cv: got %b expected 0", seen);
    else n_pass++;
    do_frame({8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1}, 0, '0, "after_reset");
  endtask

  task automatic test_back_to_back();
    int k;
    model({8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1});
    @(negedge clk);
    cnt_valid = 1'b1;
    set_cnt({8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1});
    @(negedge clk);
    cnt_valid = 1'b0;
    k = 1;
    while (!code_valid && k < 60) begin @(negedge clk); k++; end
    n_checks++;
    if (k !== exp_lat + 1) $display("FAIL b2b first_latency: got %0d expected %0d", k, exp_lat + 1);
    else n_pass++;
    n_checks++;
    if (hc_v !== exp_hc) $display("FAIL b2b first_hc: got %h expected %h", hc_v, exp_hc);
    else n_pass++;
    cnt_valid = 1'b1;
    set_cnt('0);
    @(negedge clk);
    cnt_valid = 1'b0;
    n_checks++;
    if ({hc_v, m_v} !== 96'd0) $display("FAIL b2b cleared: got %h expected 0", {hc_v, m_v});
    else n_pass++;
    n_checks++;
    if (busy !== 1'b1) $display("FAIL b2b accepted_busy: got %b expected 1", busy);
    else n_pass++;
    model('0);
    k = 1;
    while (!code_valid && k < 60) begin @(negedge clk); k++; end
    n_checks++;
    if (k !== exp_lat + 1) $display("FAIL b2b second_latency: got %0d expected %0d", k, exp_lat + 1);
    else n_pass++;
    n_checks++;
    if ({hc_v, m_v} !== {exp_hc, exp_m}) $display("FAIL b2b second_codes: got %h expected %h", {hc_v, m_v}, {exp_hc, exp_m});
    else n_pass++;
  endtask

`ifdef HUFF_ZERO_SKIP_EN
  task automatic test_zero_skip();
    do_frame({8'd0, 8'd0, 8'd0, 8'd0, 8'd7, 8'd0}, 0, '0, "zero_skip");
    n_checks++;
    if ({hc_v, m_v} !== {48'd0, 48'h00_00_00_00_01_00}) $display("FAIL zero_skip const: got %h", {hc_v, m_v});
    else n_pass++;
  endtask
`endif

  task automatic test_random();
    logic [5:0][7:0] c, ic;
    int mode, inj;
    for (int r = 0; r < 24; r++) begin
      mode = int'($urandom_range(0, 2));
      for (int i = 0; i < 6; i++) begin
        if (mode == 0) c[i] = 8'($urandom_range(0, 255));
        else if (mode == 1) c[i] = 8'($urandom_range(0, 3));
        else c[i] = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 255)) : 8'd0;
        ic[i] = 8'($urandom_range(0, 255));
      end
      model(c);
      inj = (exp_lat > 0) ? int'($urandom_range(1, exp_lat)) : 0;
      do_frame(c, inj, ic, "random");
    end
  endtask

  initial begin
    test_reset();
    test_known();
    test_all_zero();
    test_ignore_busy();
    test_mid_reset();
    test_back_to_back();
`ifdef HUFF_ZERO_SKIP_EN
    test_zero_skip();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
